// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
// FSM state and quarter encodings, byte size and ACK/NACK levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_STOP
    } state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_e;

    localparam int   BITS_PER_BYTE = 8;
    localparam logic ACK           = 1'b0;
    localparam logic NACK          = 1'b1;

    // Open-drain: a 0 bit pulls the line low, a 1 bit releases it.
    function automatic logic drive_bit(input logic b);
        return ~b;
    endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-slot timer for the I2C master: CLK_DIV clocks per quarter.
// Ports: run enables counting, i_scl stretch input, quarter/sample/slot_done out.
module i2c_bit_timer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     run,
    input  logic     i_scl,
    output quarter_e quarter,
    output logic     sample,
    output logic     slot_done
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    quarter_e      qtr_q, qtr_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        qtr_d = qtr_q;
        if (!run) begin
            cnt_d = '0;
            qtr_d = Q0;
        end else if (qtr_q == Q1 && !i_scl) begin
            // SCL released but still low: a slave is stretching.
            cnt_d = cnt_q;
        end else if (wrap) begin
            cnt_d = '0;
            qtr_d = quarter_e'(qtr_q + 2'd1);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            qtr_q <= Q0;
        end else begin
            cnt_q <= cnt_d;
            qtr_q <= qtr_d;
        end
    end

    assign quarter   = qtr_q;
    assign sample    = run && (qtr_q == Q2) && (cnt_q == '0);
    assign slot_done = run && (qtr_q == Q3) && wrap;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, STOP.
// Ports: req_* request in, rsp_* result out, i_/o_ SCL/SDA open-drain bus.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic       req_rw,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl,
    output logic       o_sda,
    output logic       o_scl_en,
    output logic       o_sda_en
);

    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] addr_sh_q, addr_sh_d;
    logic [7:0] data_q, data_d;
    logic       rw_q, rw_d;
    logic       nack_q, nack_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rsp_valid_q, rsp_valid_d;

    quarter_e   quarter;
    logic       sample;
    logic       slot_done;
    logic       run;
    logic       accept;
    logic       mid_low;
    logic       scl_en;
    logic       sda_en;

    assign run = (state_q != S_IDLE);

    i2c_bit_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .i_scl    (i_scl),
        .quarter  (quarter),
        .sample   (sample),
        .slot_done(slot_done)
    );

    // Ready stays low through the rsp_valid cycle.
    assign req_ready = (state_q == S_IDLE) && !rsp_valid_q;
    assign busy      = ~req_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_sh_d   = addr_sh_q;
        data_d      = data_q;
        rw_d        = rw_q;
        nack_d      = nack_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    addr_sh_d = {req_addr, req_rw};
                    rw_d      = req_rw;
                    // Reads shift into a cleared register.
                    data_d    = req_rw ? 8'h00 : req_wdata;
                    nack_d    = 1'b0;
                    rdata_d   = 8'h00;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (slot_done) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (slot_done) begin
                    addr_sh_d = {addr_sh_q[6:0], 1'b0};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_ADDR_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (sample) nack_d = i_sda;
                if (slot_done) state_d = nack_q ? S_STOP : S_DATA;
            end
            S_DATA: begin
                if (sample && rw_q) data_d = {data_q[6:0], i_sda};
                if (slot_done) begin
                    if (!rw_q) data_d = {data_q[6:0], 1'b0};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_DATA_ACK: begin
                if (sample && !rw_q && i_sda == NACK) nack_d = 1'b1;
                if (slot_done) state_d = S_STOP;
            end
            S_STOP: begin
                if (slot_done) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rdata_d     = rw_q ? data_q : 8'h00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mid_low = (quarter == Q0) || (quarter == Q3);

    always_comb begin
        scl_en = 1'b0;
        sda_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                scl_en = 1'b0;
            end
            S_START: begin
                scl_en = (quarter == Q3);
                sda_en = (quarter == Q2) || (quarter == Q3);
            end
            S_ADDR: begin
                scl_en = mid_low;
                sda_en = drive_bit(addr_sh_q[7]);
            end
            S_DATA: begin
                scl_en = mid_low;
                sda_en = !rw_q && drive_bit(data_q[7]);
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                // Read data ACK slot: master leaves SDA high (NACK).
                scl_en = mid_low;
            end
            S_STOP: begin
                scl_en = (quarter == Q0);
                sda_en = (quarter == Q0) || (quarter == Q1);
            end
            default: scl_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            addr_sh_q   <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_sh_q   <= addr_sh_d;
            data_q      <= data_d;
            rw_q        <= rw_d;
            nack_q      <= nack_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;
    assign o_scl     = 1'b0;
    assign o_sda     = 1'b0;
    assign o_scl_en  = scl_en;
    assign o_sda_en  = sda_en;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus monitor, slave model and reference model.
// Random and directed single-byte transactions with CLK_DIV=4.
module tb_i2c_master_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic       req_rw;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       i_scl;
    logic       i_sda;
    logic       o_scl;
    logic       o_sda;
    logic       o_scl_en;
    logic       o_sda_en;

    logic stretch = 1'b0;
    logic slv_low = 1'b0;

    assign i_scl = ~o_scl_en & ~stretch;
    assign i_sda = ~o_sda_en & ~slv_low;

    i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_rw   (req_rw),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_nack (rsp_nack),
        .busy     (busy),
        .i_scl    (i_scl),
        .i_sda    (i_sda),
        .o_scl    (o_scl),
        .o_sda    (o_sda),
        .o_scl_en (o_scl_en),
        .o_sda_en (o_sda_en)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Slave configuration for the current transaction.
    logic       s_present = 1'b1;
    logic       s_rw      = 1'b0;
    logic       s_dnack   = 1'b0;
    logic [7:0] s_data    = 8'h00;
    int         s_stretch = 0;

    // Monitor state.
    int          fall_cnt = 0;
    int          rel_cnt  = 0;
    int          cyc      = 0;
    int          gap      = 1000;
    int          mark_gap = 0;
    int          starts   = 0;
    int          stops    = 0;
    int          done_cnt = 0;
    int          sl       = 0;
    logic [31:0] obs      = 0;
    int          nobs     = 0;
    logic        pscl     = 1'b1;
    logic        psda     = 1'b1;
    logic        pscl_en  = 1'b0;
    logic        prsp     = 1'b0;

    // Snapshot of the last completed transaction.
    logic [31:0] l_bits   = 0;
    int          l_n      = 0;
    int          l_lat    = 0;
    logic [7:0]  l_rdata  = 8'h00;
    logic        l_nack   = 1'b0;
    int          l_starts = 0;
    int          l_stops  = 0;

    always @(negedge clk) begin
        logic scl;
        logic sda;
        int   s;
        cyc++;
        gap++;
        if (prsp) begin
            chk("ready_after_rsp", 32'(req_ready), 32'd1);
            chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        end
        if (stretch) begin
            sl--;
            if (sl == 0) stretch = 1'b0;
        end else if (pscl_en && !o_scl_en) begin
            rel_cnt++;
            if (rel_cnt == 4 && s_stretch > 0) begin
                stretch = 1'b1;
                sl      = s_stretch;
            end
        end
        scl = ~o_scl_en & ~stretch;
        sda = ~o_sda_en & ~slv_low;
        if (!pscl && scl) begin
            obs = {obs[30:0], sda};
            nobs++;
        end
        if (pscl && scl && psda && !sda) starts++;
        if (pscl && scl && !psda && sda) stops++;
        if (pscl && !scl) begin
            fall_cnt++;
            s = fall_cnt - 1;
            slv_low = 1'b0;
            if (s == 8)
                slv_low = s_present;
            else if (s >= 9 && s <= 16 && s_rw && s_present)
                slv_low = !s_data[16-s];
            else if (s == 17 && !s_rw && s_present)
                slv_low = !s_dnack;
        end
        if (rsp_valid) begin
            done_cnt++;
            l_bits   = obs;
            l_n      = nobs;
            l_lat    = cyc - 1;
            l_rdata  = rsp_rdata;
            l_nack   = rsp_nack;
            l_starts = starts;
            l_stops  = stops;
            gap      = 0;
        end
        if (req_valid && req_ready) begin
            mark_gap = gap;
            fall_cnt = 0;
            rel_cnt  = 0;
            cyc      = 0;
            starts   = 0;
            stops    = 0;
            obs      = 0;
            nobs     = 0;
        end
        pscl    = scl;
        psda    = ~o_sda_en & ~slv_low;
        pscl_en = o_scl_en;
        prsp    = rsp_valid;
    end

    task automatic set_slave(input logic rw, input logic pres,
                             input logic [7:0] sd, input logic dn,
                             input int st);
        s_rw      = rw;
        s_present = pres;
        s_data    = sd;
        s_dnack   = dn;
        s_stretch = st;
    endtask

    task automatic issue(input logic [6:0] a, input logic rw,
                         input logic [7:0] wd, input logic pres,
                         input logic [7:0] sd, input logic dn,
                         input int st);
        set_slave(rw, pres, sd, dn, st);
        req_addr  = a;
        req_rw    = rw;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("accepted", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 1000 && done_cnt == d0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rsp_seen", 32'(done_cnt), 32'(d0 + 1));
    endtask

    // Reference: serialised bus bits, latency and result from the request.
    task automatic check_txn(input logic [6:0] a, input logic rw,
                             input logic [7:0] wd, input logic pres,
                             input logic [7:0] sd, input logic dn,
                             input int st);
        logic [31:0] eb;
        int          en;
        logic [7:0]  ab;
        logic [7:0]  db;
        int          lat;
        eb = 0;
        en = 0;
        ab = {a, rw};
        for (int i = 7; i >= 0; i--) begin
            eb = {eb[30:0], ab[i]};
            en++;
        end
        eb = {eb[30:0], !pres};
        en++;
        if (pres) begin
            db = rw ? sd : wd;
            for (int i = 7; i >= 0; i--) begin
                eb = {eb[30:0], db[i]};
                en++;
            end
            eb = {eb[30:0], rw ? 1'b1 : dn};
            en++;
        end
        eb = {eb[30:0], 1'b0};
        en++;
        lat = (pres ? 80 : 44) * DIV + st;
        chk("nbits", 32'(l_n), 32'(en));
        chk("bits", l_bits, eb);
        chk("latency", 32'(l_lat), 32'(lat));
        chk("rdata", 32'(l_rdata), 32'((pres && rw) ? sd : 8'h00));
        chk("nack", 32'(l_nack), 32'(!pres || (!rw && dn)));
        chk("start_cond", 32'(l_starts), 32'd1);
        chk("stop_cond", 32'(l_stops), 32'd1);
        chk("rdata_now", 32'(rsp_rdata), 32'(l_rdata));
        chk("o_scl_o_sda", 32'({o_scl, o_sda}), 32'd0);
    endtask

    task automatic run(input logic [6:0] a, input logic rw,
                       input logic [7:0] wd, input logic pres,
                       input logic [7:0] sd, input logic dn,
                       input int st);
        int d0;
        d0 = done_cnt;
        issue(a, rw, wd, pres, sd, dn, st);
        req_valid = 1'b0;
        wait_done(d0);
        check_txn(a, rw, wd, pres, sd, dn, st);
    endtask

    initial begin
        logic [6:0] ra;
        logic       rrw;
        logic [7:0] rwd;
        logic       rpres;
        logic [7:0] rsd;
        logic       rdn;
        int         rst_len;
        int         d0;

        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_rw    = 1'b0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_nack", 32'(rsp_nack), 32'd0);
        chk("rst_scl_en", 32'(o_scl_en), 32'd0);
        chk("rst_sda_en", 32'(o_sda_en), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_scl", 32'(o_scl_en), 32'd0);

        run(7'h27, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 0);
        run(7'h27, 1'b1, 8'h00, 1'b1, 8'h3C, 1'b0, 0);
        run(7'h27, 1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 0);
        run(7'h27, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 50);

        for (int n = 0; n < 20; n++) begin
            ra      = 7'($urandom);
            rrw     = 1'($urandom);
            rwd     = 8'($urandom);
            rpres   = ($urandom_range(0, 3) != 0);
            rsd     = 8'($urandom);
            rdn     = ($urandom_range(0, 3) == 0);
            rst_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            chk("rdata_hold", 32'(rsp_rdata), 32'(l_rdata));
            chk("nack_hold", 32'(rsp_nack), 32'(l_nack));
            run(ra, rrw, rwd, rpres, rsd, rdn, rst_len);
        end

        // Reset in the middle of the data byte.
        d0 = done_cnt;
        issue(7'h55, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 0);
        req_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (fall_cnt >= 12 && o_scl_en && o_sda_en) break;
            @(posedge clk);
            #1;
        end
        chk("pre_rst_drive", 32'({o_scl_en, o_sda_en}), 32'd3);
        rst = 1'b0;
        #1;
        chk("midrst_scl_en", 32'(o_scl_en), 32'd0);
        chk("midrst_sda_en", 32'(o_sda_en), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_rsp", 32'(done_cnt), 32'(d0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        run(7'h3A, 1'b1, 8'h00, 1'b1, 8'hC3, 1'b0, 0);

        // req_valid held with changing fields: only the first executes.
        d0 = done_cnt;
        issue(7'h12, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b0, 0);
        req_addr  = 7'h61;
        req_rw    = 1'b1;
        req_wdata = 8'hFF;
        wait_done(d0);
        set_slave(1'b1, 1'b1, 8'h96, 1'b0, 0);
        check_txn(7'h12, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b0, 0);
        @(posedge clk);
        #1;
        chk("reaccept_busy", 32'(busy), 32'd1);
        chk("reaccept_gap", 32'(mark_gap), 32'd1);
        req_valid = 1'b0;
        wait_done(d0 + 1);
        check_txn(7'h61, 1'b1, 8'hFF, 1'b1, 8'h96, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
